// File: rtl/snake_pkg.sv
// Shared colours, background state encoding and index-width helper for the snake renderer.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package snake_pkg;

  localparam logic [11:0] RED     = 12'hF00;
  localparam logic [11:0] YELLOW  = 12'hFF0;
  localparam logic [11:0] WHITE   = 12'hFFF;
  localparam logic [11:0] BLACK   = 12'h000;
  localparam logic [11:0] GREEN   = 12'h0F0;
  localparam logic [11:0] BLUE    = 12'h00F;
  localparam logic [11:0] DKGREEN = 12'h080;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } bg_state_t;

  // Bits needed to hold a cell index row*cols+col; never narrower than 1.
  function automatic int cell_idx_w(input int cols, input int rows);
    return (cols * rows > 1) ? $clog2(cols * rows) : 1;
  endfunction

endpackage

// File: rtl/snake_cell_tracker.sv
// Tracks grid column/row and in-cell pixel offsets from hCount/vCount using counters only.
// Latency: outputs describe the pixel on hCount/vCount in the same cycle (combinational on registered state).
// Backpressure: none; assumes hCount advances by one per Clk across a scanned span.
module snake_cell_tracker
  import snake_pkg::*;
#(
  parameter int GRID_COLS = 16,
  parameter int GRID_ROWS = 16,
  parameter int CELL_W    = 40,
  parameter int CELL_H    = 30,
  parameter int BLOCK_W   = 20,
  parameter int BLOCK_H   = 20,
  parameter int H_ORIGIN  = 144,
  parameter int V_ORIGIN  = 35,
  parameter int BORDER    = 20,
  localparam int CW = $clog2(GRID_COLS + 1),
  localparam int RW = $clog2(GRID_ROWS + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [9:0]    hCount,
  input  logic [9:0]    vCount,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          on_grid,
  output logic          in_block,
  output logic          border
);

  localparam int XW   = $clog2(CELL_W);
  localparam int YW   = $clog2(CELL_H);
  localparam int XOFF = (CELL_W - BLOCK_W) / 2;
  localparam int YOFF = (CELL_H - BLOCK_H) / 2;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [XW-1:0] xin_q, xin_c;
  logic [YW-1:0] yin_q, yin_c;

  // Horizontal position of this pixel: reload at the origin, else one step past last cycle.
  always_comb begin
    col   = col_q;
    xin_c = xin_q;
    if (hCount == 10'(H_ORIGIN)) begin
      col   = '0;
      xin_c = '0;
    end else if (xin_q == XW'(CELL_W - 1)) begin
      xin_c = '0;
      if (col_q != CW'(GRID_COLS)) col = col_q + CW'(1);
    end else begin
      xin_c = xin_q + XW'(1);
    end
  end

  // Vertical position: only moves on the first pixel of a line, reloads at the visible origin.
  always_comb begin
    row   = row_q;
    yin_c = yin_q;
    if (hCount == 10'd0) begin
      if (vCount == 10'(V_ORIGIN)) begin
        row   = '0;
        yin_c = '0;
      end else if (yin_q == YW'(CELL_H - 1)) begin
        yin_c = '0;
        if (row_q != RW'(GRID_ROWS)) row = row_q + RW'(1);
      end else begin
        yin_c = yin_q + YW'(1);
      end
    end
  end

  // Remember the current position; reset parks both axes off-grid until the next origin.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      col_q <= CW'(GRID_COLS);
      row_q <= RW'(GRID_ROWS);
      xin_q <= '0;
      yin_q <= '0;
    end else begin
      col_q <= col;
      row_q <= row;
      xin_q <= xin_c;
      yin_q <= yin_c;
    end
  end

  // Pixel classification; border assumes BORDER fits inside one edge cell on each axis.
  always_comb begin
    on_grid  = (int'(col) < GRID_COLS) && (int'(row) < GRID_ROWS);
    in_block = (int'(xin_c) >= XOFF) && (int'(xin_c) < XOFF + BLOCK_W) &&
               (int'(yin_c) >= YOFF) && (int'(yin_c) < YOFF + BLOCK_H);
    border   = on_grid && (
                 ((col == '0) && (int'(xin_c) < BORDER)) ||
                 ((int'(col) == GRID_COLS - 1) && (int'(xin_c) >= CELL_W - BORDER)) ||
                 ((row == '0) && (int'(yin_c) < BORDER)) ||
                 ((int'(row) == GRID_ROWS - 1) && (int'(yin_c) >= CELL_H - BORDER)));
  end

endmodule

// File: rtl/snake_grid_renderer.sv
// Pixel renderer for the snake playfield: snapshots game state per frame and colours each pixel.
// Latency: 2 Clk from hCount/vCount/Bright to rgb and Bright_out; frame_start 1 Clk after hCount==vCount==0.
// Backpressure: none; streams one pixel per Clk.
module snake_grid_renderer
  import snake_pkg::*;
#(
  parameter int GRID_COLS    = 16,
  parameter int GRID_ROWS    = 16,
  parameter int CELL_W       = 40,
  parameter int CELL_H       = 30,
  parameter int BLOCK_W      = 20,
  parameter int BLOCK_H      = 20,
  parameter int MAX_LEN      = 16,
  parameter int H_ORIGIN     = 144,
  parameter int V_ORIGIN     = 35,
  parameter int BORDER       = 20,
  parameter int BLINK_FRAMES = 30,
  localparam int CB = cell_idx_w(GRID_COLS, GRID_ROWS),
  localparam int SB = $clog2(MAX_LEN + 1)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Bright,
  input  logic [9:0]            hCount,
  input  logic [9:0]            vCount,
  input  logic                  Q_init,
  input  logic                  Q_win,
  input  logic                  Q_lose,
  input  logic                  Q_check,
  input  logic [CB-1:0]         Apple,
  input  logic [SB-1:0]         Size,
  input  logic [MAX_LEN*CB-1:0] Locations_Flat,
  output logic [11:0]           rgb,
  output logic                  Bright_out,
  output logic                  frame_start,
  output logic [11:0]           background
);

  localparam int NCELLS = GRID_COLS * GRID_ROWS;
  localparam int CW     = $clog2(GRID_COLS + 1);
  localparam int RW     = $clog2(GRID_ROWS + 1);
  localparam int BCW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic fs_now;
  assign fs_now = (hCount == 10'd0) && (vCount == 10'd0);

  // Apple position is only meaningful once the game has checked it at least once.
  logic [CB-1:0] apple_reg;
  logic          apple_valid;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      apple_reg   <= '0;
      apple_valid <= 1'b0;
    end else if (Q_check) begin
      apple_reg   <= Apple;
      apple_valid <= 1'b1;
    end
  end

  // Frame-start snapshot so the whole frame renders from one consistent game state.
  logic [CB-1:0] loc_sh [MAX_LEN];
  logic [SB-1:0] size_sh;
  logic [CB-1:0] apple_sh;
  logic          apple_sh_vld;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < MAX_LEN; i++) loc_sh[i] <= '0;
      size_sh      <= '0;
      apple_sh     <= '0;
      apple_sh_vld <= 1'b0;
    end else if (fs_now) begin
      for (int i = 0; i < MAX_LEN; i++) loc_sh[i] <= Locations_Flat[(MAX_LEN-i)*CB-1 -: CB];
      size_sh      <= (Size > SB'(MAX_LEN)) ? SB'(MAX_LEN) : Size;
      apple_sh     <= apple_reg;
      apple_sh_vld <= apple_valid;
    end
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          on_grid, in_block, border;

  snake_cell_tracker #(
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS),
    .CELL_W    (CELL_W),
    .CELL_H    (CELL_H),
    .BLOCK_W   (BLOCK_W),
    .BLOCK_H   (BLOCK_H),
    .H_ORIGIN  (H_ORIGIN),
    .V_ORIGIN  (V_ORIGIN),
    .BORDER    (BORDER)
  ) u_tracker (
    .Clk      (Clk),
    .Reset    (Reset),
    .hCount   (hCount),
    .vCount   (vCount),
    .col      (col),
    .row      (row),
    .on_grid  (on_grid),
    .in_block (in_block),
    .border   (border)
  );

  // Stage 1: register cell index and pixel flags.
  logic [CB-1:0] cell_s1;
  logic          on_grid_s1, in_block_s1, border_s1, bright_s1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cell_s1     <= '0;
      on_grid_s1  <= 1'b0;
      in_block_s1 <= 1'b0;
      border_s1   <= 1'b0;
      bright_s1   <= 1'b0;
    end else begin
      cell_s1     <= CB'(int'(row) * GRID_COLS + int'(col));
      on_grid_s1  <= on_grid;
      in_block_s1 <= in_block;
      border_s1   <= border;
      bright_s1   <= Bright;
    end
  end

  // Stage 2 comparators and colour priority: blank, head, body, apple, border, background.
  logic        head_hit, body_hit, apple_hit, hit_ok;
  logic [11:0] pix;

  always_comb begin
    head_hit  = 1'b0;
    body_hit  = 1'b0;
    hit_ok    = on_grid_s1 && in_block_s1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (hit_ok && (SB'(i) < size_sh) && (int'(loc_sh[i]) < NCELLS) && (loc_sh[i] == cell_s1)) begin
        if (i == 0) head_hit = 1'b1;
        else        body_hit = 1'b1;
      end
    end
    apple_hit = hit_ok && apple_sh_vld && (int'(apple_sh) < NCELLS) && (apple_sh == cell_s1);
    pix = background;
    if (!bright_s1)     pix = BLACK;
    else if (head_hit)  pix = DKGREEN;
    else if (body_hit)  pix = GREEN;
    else if (apple_hit) pix = RED;
    else if (border_s1) pix = BLACK;
  end

  // Output registers aligned two cycles behind the scan inputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb         <= BLACK;
      Bright_out  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= pix;
      Bright_out  <= bright_s1;
      frame_start <= fs_now;
    end
  end

  // Background FSM state register.
  bg_state_t state_q, state_n;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_INIT;
    else       state_q <= state_n;
  end

  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;
  logic [11:0]    bg_n;

  // Next state from the game flags by priority, and the colour this state paints.
  always_comb begin
    state_n = ST_PLAY;
    bg_n    = WHITE;
    if (Q_init)      state_n = ST_INIT;
    else if (Q_lose) state_n = ST_LOSE;
    else if (Q_win)  state_n = ST_WIN;
    case (state_q)
      ST_WIN:  bg_n = BLUE;
      ST_LOSE: bg_n = blink_phase ? BLACK : YELLOW;
      default: bg_n = WHITE;
    endcase
  end

  // Background only changes on frame boundaries; blink counts frames spent in LOSE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      background  <= WHITE;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if ((state_q != ST_LOSE) && (state_n == ST_LOSE)) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (fs_now && (state_q == ST_LOSE)) begin
        if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BCW'(1);
        end
      end
      if (fs_now) background <= bg_n;
    end
  end

endmodule

// File: tb/tb_snake_grid_renderer.sv
// Self-checking bench: directed scenarios plus randomized frames against a geometric reference model.
// Latency: expects rgb/Bright_out two cycles after the scan inputs, frame_start/background one cycle after.
// Backpressure: none; the bench drives one pixel per clock.
module tb_snake_grid_renderer;

  localparam logic [11:0] C_RED = 12'hF00, C_YEL = 12'hFF0, C_WHT = 12'hFFF, C_BLK = 12'h000;
  localparam logic [11:0] C_GRN = 12'h0F0, C_BLU = 12'h00F, C_DKG = 12'h080;
  localparam int M_INIT = 0, M_PLAY = 1, M_WIN = 2, M_LOSE = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1, Bright = 1'b0;
  logic [9:0]  hCount = '0, vCount = '0;
  logic        Q_init = 1'b0, Q_win = 1'b0, Q_lose = 1'b0, Q_check = 1'b0;
  logic [7:0]  Apple = '0;
  logic [4:0]  Size = '0;
  logic [127:0] Locations_Flat = '0;
  logic [11:0] rgb, background;
  logic        Bright_out, frame_start;

  snake_grid_renderer dut (
    .Clk(Clk), .Reset(Reset), .Bright(Bright), .hCount(hCount), .vCount(vCount),
    .Q_init(Q_init), .Q_win(Q_win), .Q_lose(Q_lose), .Q_check(Q_check),
    .Apple(Apple), .Size(Size), .Locations_Flat(Locations_Flat),
    .rgb(rgb), .Bright_out(Bright_out), .frame_start(frame_start), .background(background)
  );

  always #5 Clk = ~Clk;

  int total = 0, bad = 0;
  int cur_line = 0;
  logic [7:0] locs [16];

  // reference model state
  int         m_slocs [16];
  int         m_ssize = 0, m_sapple = 0, m_apple = 0, m_state = M_INIT, m_lose_frames = 0;
  logic       m_sapple_vld = 1'b0, m_apple_vld = 1'b0;
  logic [11:0] m_bg = C_WHT;

  // pipeline of expectations
  logic        prev_vld = 1'b0, prev_b = 1'b0, prev_dv = 1'b0, d_next_v = 1'b0;
  logic [11:0] prev_e = '0, prev_de = '0, d_next_e = '0;
  int          prev_h = 0, prev_v = 0;
  string       prev_tag = "", d_next_tag = "";

  task automatic chk(input logic [11:0] got, input logic [11:0] exp, input string tag);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_pix(input int h, input int v, input logic b);
    int x, y, c;
    logic inb;
    if (!b) return C_BLK;
    x = h - 144;
    y = v - 35;
    if (x < 0 || x >= 640 || y < 0 || y >= 480) return m_bg;
    c   = (y / 30) * 16 + (x / 40);
    inb = ((x % 40) >= 10) && ((x % 40) < 30) && ((y % 30) >= 5) && ((y % 30) < 25);
    if (inb) begin
      if (m_ssize >= 1 && m_slocs[0] == c) return C_DKG;
      for (int i = 1; i < m_ssize; i++) if (m_slocs[i] == c) return C_GRN;
      if (m_sapple_vld && m_sapple == c) return C_RED;
    end
    if (x < 20 || x >= 620 || y < 20 || y >= 460) return C_BLK;
    return m_bg;
  endfunction

  task automatic apply_locs();
    for (int i = 0; i < 16; i++) Locations_Flat[(16-i)*8-1 -: 8] = locs[i];
  endtask

  task automatic step(input int h, input int v, input logic b, input logic rst);
    logic [11:0] e;
    logic fs;
    int   nst;
    hCount = 10'(h); vCount = 10'(v); Bright = b; Reset = rst;
    fs = (h == 0) && (v == 0);
    if (!rst && fs) begin
      for (int i = 0; i < 16; i++) m_slocs[i] = int'(locs[i]);
      m_ssize      = (int'(Size) > 16) ? 16 : int'(Size);
      m_sapple     = m_apple;
      m_sapple_vld = m_apple_vld;
      if (m_state == M_WIN) m_bg = C_BLU;
      else if (m_state == M_LOSE) begin
        m_lose_frames++;
        m_bg = (((m_lose_frames - 1) / 30) % 2 == 1) ? C_BLK : C_YEL;
      end else m_bg = C_WHT;
    end
    e = model_pix(h, v, b);
    @(posedge Clk);
    #1;
    if (rst) begin
      m_ssize = 0; m_sapple_vld = 1'b0; m_apple_vld = 1'b0; m_apple = 0;
      m_state = M_INIT; m_bg = C_WHT; m_lose_frames = 0;
      chk(rgb, C_BLK, "reset_rgb");
      chk({11'b0, Bright_out}, 12'h0, "reset_bright_out");
      chk({11'b0, frame_start}, 12'h0, "reset_frame_start");
      chk(background, C_WHT, "reset_background");
    end else begin
      if (Q_check) begin m_apple = int'(Apple); m_apple_vld = 1'b1; end
      nst = Q_init ? M_INIT : Q_lose ? M_LOSE : Q_win ? M_WIN : M_PLAY;
      if (nst == M_LOSE && m_state != M_LOSE) m_lose_frames = 0;
      m_state = nst;
      if (prev_vld) begin
        chk(rgb, prev_e, $sformatf("rgb(h=%0d,v=%0d)", prev_h, prev_v));
        chk({11'b0, Bright_out}, {11'b0, prev_b}, $sformatf("bright_out(h=%0d,v=%0d)", prev_h, prev_v));
      end
      if (prev_dv) chk(rgb, prev_de, prev_tag);
      chk({11'b0, frame_start}, {11'b0, fs}, $sformatf("frame_start(h=%0d,v=%0d)", h, v));
      chk(background, m_bg, "background_model");
    end
    prev_vld = 1'b1;
    prev_e   = rst ? C_BLK : e;
    prev_b   = rst ? 1'b0 : b;
    prev_h   = h;
    prev_v   = v;
    prev_dv  = d_next_v && !rst;
    prev_de  = d_next_e;
    prev_tag = d_next_tag;
    d_next_v = 1'b0;
  endtask

  task automatic idle();
    step(1, cur_line, 1'b0, 1'b0);
  endtask

  task automatic frame();
    step(0, 0, 1'b0, 1'b0);
    cur_line = 0;
  endtask

  task automatic goto_line(input int v);
    for (int l = cur_line + 1; l <= v; l++) step(0, l, 1'b0, 1'b0);
    if (v > cur_line) cur_line = v;
  endtask

  task automatic scan(input int v, input int h_end);
    goto_line(v);
    for (int x = 144; x <= h_end; x++) step(x, v, 1'b1, 1'b0);
    idle();
  endtask

  task automatic pix(input int h, input int v, input logic b, input logic [11:0] exp, input string tag);
    goto_line(v);
    for (int x = 144; x < h; x++) step(x, v, 1'b1, 1'b0);
    d_next_v = 1'b1; d_next_e = exp; d_next_tag = tag;
    step(h, v, b, 1'b0);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) locs[i] = '0;
    apply_locs();

    // 1: reset, head over border, border outside block
    step(1, 0, 1'b0, 1'b1);
    step(1, 0, 1'b0, 1'b1);
    Size = 5'd1; locs[0] = 8'h00; apply_locs();
    idle(); idle();
    frame();
    chk({11'b0, frame_start}, 12'h1, "frame_start_pulse");
    pix(160, 50, 1'b1, C_DKG, "head_beats_border");
    pix(150, 50, 1'b1, C_BLK, "border_outside_block");

    // 2: body/head colours, snapshot holds through mid-frame changes
    Size = 5'd3; locs[0] = 8'h22; locs[1] = 8'h23; locs[2] = 8'h24; apply_locs();
    frame();
    pix(280, 100, 1'b1, C_GRN, "body_0x23");
    pix(240, 100, 1'b1, C_DKG, "head_0x22");
    locs[0] = 8'h55; locs[1] = 8'h56; locs[2] = 8'h57; apply_locs();
    pix(240, 110, 1'b1, C_DKG, "snapshot_held");
    frame();
    pix(240, 100, 1'b1, C_WHT, "old_head_gone");
    pix(364, 200, 1'b1, C_DKG, "new_head_0x55");

    // 3: apple hidden until first Q_check and next snapshot
    frame();
    pix(200, 80, 1'b1, C_WHT, "no_apple_yet");
    Apple = 8'h11; Q_check = 1'b1; idle(); Q_check = 1'b0;
    pix(200, 85, 1'b1, C_WHT, "apple_waits_for_frame");
    frame();
    pix(200, 80, 1'b1, C_RED, "apple_0x11");

    // 4: lose blink, flag priority, win
    Q_lose = 1'b1; idle(); idle();
    for (int k = 1; k <= 61; k++) begin
      frame();
      if (k == 1 || k == 30) chk(background, C_YEL, $sformatf("lose_yellow_f%0d", k));
      if (k == 31 || k == 60) chk(background, C_BLK, $sformatf("lose_black_f%0d", k));
      if (k == 61) chk(background, C_YEL, "lose_yellow_f61");
    end
    Q_init = 1'b1; idle(); idle(); frame();
    chk(background, C_WHT, "init_over_lose");
    Q_init = 1'b0; Q_lose = 1'b0; Q_win = 1'b1; idle(); idle(); frame();
    chk(background, C_BLU, "win_blue");
    Q_win = 1'b0; idle(); idle(); frame();
    chk(background, C_WHT, "play_white");

    // 5: size clamp, far corner cell, Bright low
    Size = 5'd20; locs[0] = 8'h33;
    for (int i = 1; i < 15; i++) locs[i] = 8'(8'hE0 + i);
    locs[15] = 8'hFF; apply_locs();
    frame();
    pix(284, 140, 1'b1, C_DKG, "head_0x33");
    pix(284, 140, 1'b0, C_BLK, "bright_low");
    pix(764, 500, 1'b1, C_GRN, "seg15_at_0xFF");

    // 6: reset mid-line
    Size = 5'd1; locs[0] = 8'h22; apply_locs();
    Q_win = 1'b1; idle(); idle(); frame();
    chk(background, C_BLU, "pre_reset_blue");
    scan(110, 250);
    for (int x = 144; x <= 250; x++) step(x, 110, 1'b1, 1'b0);
    step(251, 110, 1'b1, 1'b1);
    Q_win = 1'b0;
    cur_line = 0;
    pix(244, 110, 1'b1, C_WHT, "no_head_before_fs");
    frame();
    pix(244, 110, 1'b1, C_DKG, "head_after_fs");

    // random frames checked pixel by pixel against the model
    for (int f = 0; f < 6; f++) begin
      Size = 5'($urandom_range(0, 20));
      for (int i = 0; i < 16; i++) locs[i] = 8'($urandom_range(0, 255));
      apply_locs();
      Apple = 8'($urandom_range(0, 255)); Q_check = 1'b1; idle(); Q_check = 1'b0;
      frame();
      for (int k = 0; k < 4; k++) scan(35 + k * 120 + int'($urandom_range(0, 119)), 783);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
